nonce_encoder: RTL and testbench

NONCE_ENCODER -- requirements
Module: nonce_encoder

---
 rtl/nonce_encoder_pkg.sv | 16 +
 rtl/nonce_encoder.sv | 156 +++++++++++++++
 tb/tb_nonce_encoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/nonce_encoder_pkg.sv
// Shared types and sizing helpers for the nonce encoder/decoder pair.
package nonce_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BROADCAST = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } enc_state_t;

  // Low log2(NUM_CORES) nonce bits are the core index, so the prefix carries the rest.
  function automatic int calc_prefix_w(input int nonce_w, input int num_cores);
    return nonce_w - $clog2(num_cores);
  endfunction

endpackage

// File: rtl/nonce_encoder.sv
// Header broadcast then prefix sweep for NUM_CORES cores; all outputs registered, one cycle behind inputs.
// stall_i freezes counters, state and the pending prefix; start beats halt, stall and exhaustion.
module nonce_encoder
  import nonce_encoder_pkg::*;
#(
  parameter int  NUM_CORES     = 4,
  parameter int  BROADCAST_CNT = 5,
  parameter int  NONCE_W       = 32,
  localparam int PREFIX_W      = calc_prefix_w(NONCE_W, NUM_CORES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                newblock_i,
  input  logic                stall_i,
  input  logic                halt_i,
  output logic                valid_o,
  output logic                newblock_o,
  output logic                broadcast_o,
  output logic [PREFIX_W-1:0] nonce_prefix_o,
  output logic                exhausted_o,
  output logic                done_o
);

  localparam int                 CNT_W    = $clog2(BROADCAST_CNT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BROADCAST_CNT);
  localparam logic [PREFIX_W-1:0] PFX_MAX = '1;

  enc_state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [PREFIX_W-1:0] r_pfx, w_pfx_nxt;
  logic                r_last, w_last_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_newblock, w_newblock_nxt;
  logic                r_broadcast, w_broadcast_nxt;
  logic                r_exhausted, w_exhausted_nxt;
  logic                r_done, w_done_nxt;
  logic [PREFIX_W-1:0] r_pfx_out, w_pfx_out_nxt;
  logic                w_start;

  assign w_start = valid_i & newblock_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_pfx is the next prefix to issue; r_last marks that the final prefix has gone out.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pfx_nxt       = r_pfx;
    w_last_nxt      = r_last;
    w_valid_nxt     = 1'b0;
    w_newblock_nxt  = 1'b0;
    w_broadcast_nxt = 1'b0;
    w_exhausted_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_pfx_out_nxt   = r_pfx_out;
    if (w_start) begin
      w_state_nxt     = ST_BROADCAST;
      w_newblock_nxt  = 1'b1;
      w_broadcast_nxt = 1'b1;
      w_valid_nxt     = !stall_i;
      w_cnt_nxt       = stall_i ? '0 : CNT_W'(1);
      w_pfx_nxt       = '0;
      w_last_nxt      = 1'b0;
      w_pfx_out_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end
        ST_BROADCAST: begin
          if (halt_i) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else if (!valid_i) begin
            w_state_nxt = ST_IDLE;
          end else if (stall_i) begin
            w_broadcast_nxt = 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt   = ST_RUN;
            w_valid_nxt   = 1'b1;
            w_pfx_out_nxt = r_pfx;
            w_pfx_nxt     = r_pfx + 1'b1;
            w_last_nxt    = (r_pfx == PFX_MAX);
          end else begin
            w_broadcast_nxt = 1'b1;
            w_valid_nxt     = 1'b1;
            w_cnt_nxt       = r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (halt_i) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else if (!valid_i) begin
            w_state_nxt = ST_IDLE;
          end else if (r_last) begin
            w_state_nxt     = ST_DONE;
            w_done_nxt      = 1'b1;
            w_exhausted_nxt = 1'b1;
          end else if (stall_i) begin
            w_pfx_out_nxt = r_pfx;
          end else begin
            w_valid_nxt   = 1'b1;
            w_pfx_out_nxt = r_pfx;
            w_pfx_nxt     = r_pfx + 1'b1;
            w_last_nxt    = (r_pfx == PFX_MAX);
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_pfx       <= '0;
      r_last      <= 1'b0;
      r_valid     <= 1'b0;
      r_newblock  <= 1'b0;
      r_broadcast <= 1'b0;
      r_exhausted <= 1'b0;
      r_done      <= 1'b0;
      r_pfx_out   <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_pfx       <= w_pfx_nxt;
      r_last      <= w_last_nxt;
      r_valid     <= w_valid_nxt;
      r_newblock  <= w_newblock_nxt;
      r_broadcast <= w_broadcast_nxt;
      r_exhausted <= w_exhausted_nxt;
      r_done      <= w_done_nxt;
      r_pfx_out   <= w_pfx_out_nxt;
    end
  end

  assign valid_o        = r_valid;
  assign newblock_o     = r_newblock;
  assign broadcast_o    = r_broadcast;
  assign nonce_prefix_o = r_pfx_out;
  assign exhausted_o    = r_exhausted;
  assign done_o         = r_done;

endmodule

// File: tb/tb_nonce_encoder.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle outputs, monitor compares after each edge.
module tb_nonce_encoder;

  typedef struct {
    string       name;
    logic        v, nb, bc, ex, dn;
    logic [29:0] pfx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_valid = 0, a_newblock = 0, a_stall = 0, a_halt = 0;
  logic b_valid = 0, b_newblock = 0, b_stall = 0, b_halt = 0;
  logic a_v, a_nb, a_bc, a_ex, a_dn;
  logic b_v, b_nb, b_bc, b_ex, b_dn;
  logic [29:0] a_pfx;
  logic [3:0]  b_pfx;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nonce_encoder #(.NUM_CORES(4), .BROADCAST_CNT(5), .NONCE_W(32)) dut_a (
    .clk(clk), .rst(rst), .valid_i(a_valid), .newblock_i(a_newblock),
    .stall_i(a_stall), .halt_i(a_halt), .valid_o(a_v), .newblock_o(a_nb),
    .broadcast_o(a_bc), .nonce_prefix_o(a_pfx), .exhausted_o(a_ex), .done_o(a_dn)
  );

  nonce_encoder #(.NUM_CORES(4), .BROADCAST_CNT(5), .NONCE_W(6)) dut_b (
    .clk(clk), .rst(rst), .valid_i(b_valid), .newblock_i(b_newblock),
    .stall_i(b_stall), .halt_i(b_halt), .valid_o(b_v), .newblock_o(b_nb),
    .broadcast_o(b_bc), .nonce_prefix_o(b_pfx), .exhausted_o(b_ex), .done_o(b_dn)
  );

  function automatic exp_t mk(input string n, input logic v, input logic nb, input logic bc,
                              input logic ex, input logic dn, input logic [29:0] p);
    exp_t e;
    e.name = n; e.v = v; e.nb = nb; e.bc = bc; e.ex = ex; e.dn = dn; e.pfx = p;
    return e;
  endfunction

  task automatic compare(input string dut, input exp_t e, input logic v, input logic nb,
                         input logic bc, input logic ex, input logic dn, input logic [29:0] p);
    n_tests++;
    if ({v, nb, bc, ex, dn} !== {e.v, e.nb, e.bc, e.ex, e.dn} || p !== e.pfx) begin
      n_fail++;
      $display("FAIL %s.%s: got v=%0b nb=%0b bc=%0b ex=%0b dn=%0b pfx=%0d, expected v=%0b nb=%0b bc=%0b ex=%0b dn=%0b pfx=%0d",
               dut, e.name, v, nb, bc, ex, dn, p, e.v, e.nb, e.bc, e.ex, e.dn, e.pfx);
    end
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (q_a.size() > 0) begin
      mon_e = q_a.pop_front();
      compare("A", mon_e, a_v, a_nb, a_bc, a_ex, a_dn, a_pfx);
    end
    if (q_b.size() > 0) begin
      mon_e = q_b.pop_front();
      compare("B", mon_e, b_v, b_nb, b_bc, b_ex, b_dn, {26'd0, b_pfx});
    end
  end

  // One clock: drive inputs of the selected DUT and queue what it must show after the edge.
  task automatic cyc(input bit sel, input logic r, input logic v, input logic nb,
                     input logic st, input logic h, input exp_t e);
    @(negedge clk);
    rst = r;
    if (sel) begin
      b_valid = v; b_newblock = nb; b_stall = st; b_halt = h;
      q_b.push_back(e);
    end else begin
      a_valid = v; a_newblock = nb; a_stall = st; a_halt = h;
      q_a.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with random inputs on both DUTs
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mk("reset", 0, 0, 0, 0, 0, 0));
      b_valid = 1'($urandom_range(0, 1)); b_newblock = 1'($urandom_range(0, 1));
      b_stall = 1'($urandom_range(0, 1)); b_halt = 1'($urandom_range(0, 1));
      q_b.push_back(mk("reset", 0, 0, 0, 0, 0, 0));
    end
    b_valid = 0; b_newblock = 0; b_stall = 0; b_halt = 0;
    cyc(0, 1'b1, 0, 0, 0, 0, mk("idle_after_reset", 0, 0, 0, 0, 0, 0));

    // Start, broadcast, prefix sweep with stall at pending prefix 7, halt at 10
    cyc(0, 1, 1, 1, 0, 0, mk("start", 1, 1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, mk("broadcast", 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0, 0, mk("run", 1, 0, 0, 0, 0, 30'(i)));
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 1, 0, mk("stall_hold", 0, 0, 0, 0, 0, 7));
    for (int i = 7; i <= 10; i++) cyc(0, 1, 1, 0, 0, 0, mk("after_stall", 1, 0, 0, 0, 0, 30'(i)));
    cyc(0, 1, 1, 0, 0, 1, mk("halt_done", 0, 0, 0, 0, 1, 10));
    cyc(0, 1, 1, 0, 0, 0, mk("idle_after_halt", 0, 0, 0, 0, 0, 10));
    cyc(0, 1, 1, 0, 1, 1, mk("idle_ignores", 0, 0, 0, 0, 0, 10));

    // Start wins over a simultaneous halt at prefix 20
    cyc(0, 1, 1, 1, 0, 0, mk("start2", 1, 1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, mk("broadcast2", 1, 0, 1, 0, 0, 0));
    for (int i = 0; i <= 20; i++) cyc(0, 1, 1, 0, 0, 0, mk("run2", 1, 0, 0, 0, 0, 30'(i)));
    cyc(0, 1, 1, 1, 0, 1, mk("restart_over_halt", 1, 1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, mk("rebroadcast", 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 2; i++) cyc(0, 1, 1, 0, 0, 0, mk("rerun", 1, 0, 0, 0, 0, 30'(i)));

    // Reset mid-job, then no resume without a new start
    cyc(0, 0, 1, 1, 0, 0, mk("midjob_reset", 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 1, 0, 0, 0, mk("no_resume", 0, 0, 0, 0, 0, 0));

    // Stall during broadcast extends it; valid_i low aborts without done
    cyc(0, 1, 1, 1, 0, 0, mk("start3", 1, 1, 1, 0, 0, 0));
    cyc(0, 1, 1, 0, 1, 0, mk("bc_stall", 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, mk("broadcast3", 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, mk("run3", 1, 0, 0, 0, 0, 30'(i)));
    cyc(0, 1, 0, 0, 0, 0, mk("abort", 0, 0, 0, 0, 0, 2));
    cyc(0, 1, 0, 0, 0, 0, mk("abort_idle", 0, 0, 0, 0, 0, 2));

    // Halt during broadcast
    cyc(0, 1, 1, 1, 0, 0, mk("start4", 1, 1, 1, 0, 0, 0));
    cyc(0, 1, 1, 0, 0, 1, mk("bc_halt", 0, 0, 0, 0, 1, 0));
    cyc(0, 1, 0, 0, 0, 0, mk("bc_halt_idle", 0, 0, 0, 0, 0, 0));

    // Small prefix space: 0..15 issued, then exhaustion
    cyc(1, 1, 1, 1, 0, 0, mk("b_start", 1, 1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0, mk("b_broadcast", 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 0, 0, 0, mk("b_run", 1, 0, 0, 0, 0, 30'(i)));
    cyc(1, 1, 1, 0, 0, 0, mk("b_exhausted", 0, 0, 0, 1, 1, 15));
    cyc(1, 1, 1, 0, 0, 0, mk("b_idle", 0, 0, 0, 0, 0, 15));

    @(negedge clk);
    @(negedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
